// File: rtl/router_fifo.sv
// Router output FIFO: 16 x 9-bit {lfd, data} store with packet-length tracking.
// Optional sticky overflow port is enabled by defining ROUTER_FIFO_OVF_FLAG_EN.
module router_fifo (
  input  logic       clock,
  input  logic       reset,
  input  logic       soft_reset,
  input  logic       write_enb,
  input  logic       read_enb,
  input  logic       lfd_state,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       full,
  output logic       empty,
  output logic       pkt_busy
`ifdef ROUTER_FIFO_OVF_FLAG_EN
  ,
  output logic       overflow
`endif
);

  logic [8:0] r_mem [16];
  logic [4:0] r_wr_ptr;
  logic [4:0] r_rd_ptr;
  logic [6:0] r_pkt_cnt;
  logic [7:0] r_data_out;

  logic       w_full;
  logic       w_empty;
  logic       w_do_wr;
  logic       w_do_rd;
  logic [8:0] w_rd_word;

  assign w_full    = (r_wr_ptr[4] != r_rd_ptr[4]) && (r_wr_ptr[3:0] == r_rd_ptr[3:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_wr   = write_enb && !w_full && !soft_reset;
  assign w_do_rd   = read_enb && !w_empty && !soft_reset;
  assign w_rd_word = r_mem[r_rd_ptr[3:0]];

  // Storage needs no reset: entries outside [rd_ptr, wr_ptr) are never read.
  always_ff @(posedge clock) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[3:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 5'd1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 5'd1;
    end
  end

  // Header read loads len+1 (payload plus parity); idle output zeroes only between packets.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pkt_cnt  <= '0;
      r_data_out <= '0;
    end else if (soft_reset) begin
      r_pkt_cnt  <= '0;
      r_data_out <= '0;
    end else if (w_do_rd) begin
      r_data_out <= w_rd_word[7:0];
      if (w_rd_word[8]) begin
        r_pkt_cnt <= {1'b0, w_rd_word[7:2]} + 7'd1;
      end else if (r_pkt_cnt != '0) begin
        r_pkt_cnt <= r_pkt_cnt - 7'd1;
      end
    end else if (!read_enb && (r_pkt_cnt == '0)) begin
      r_data_out <= '0;
    end
  end

`ifdef ROUTER_FIFO_OVF_FLAG_EN
  logic r_overflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (soft_reset) begin
      r_overflow <= 1'b0;
    end else if (write_enb && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;
  assign pkt_busy = (r_pkt_cnt != '0);

endmodule
